// File: rtl/icache_loader.sv
// icache_loader: boot-time sequencer for the instruction store.
// Accepts a length header followed by N instruction halfwords and writes
// them to store slots 0..N-1, then releases the CPU via cpu_run.
// Optional build macro: ICACHE_LOADER_CHECKSUM_EN adds a trailing checksum
// word and a CHECK state that validates it before releasing the CPU.
module icache_loader #(
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 32,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ic_write_enable,
  output logic [IDX_W-1:0]  ic_write_index,
  output logic [DATA_W-1:0] ic_write_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [IDX_W-1:0]  load_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_LOAD   = 3'd2,
    S_DRAIN  = 3'd3,
    S_RUN    = 3'd4,
    S_ERROR  = 3'd5
`ifdef ICACHE_LOADER_CHECKSUM_EN
    , S_CHECK = 3'd6
`endif
  } state_e;

  // Where the FSM goes once the last instruction (or an empty header) is taken.
`ifdef ICACHE_LOADER_CHECKSUM_EN
  localparam state_e S_POST = S_CHECK;
`else
  localparam state_e S_POST = S_DRAIN;
`endif

  state_e              state_q, state_d;
  logic                in_ready_q;
  logic                we_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                cpu_run_q;
  logic                busy_q;
  logic                error_q;
  logic [IDX_W-1:0]    count_q;
  logic [IDX_W-1:0]    n_q;
  logic [IDX_W-1:0]    count_inc;
  logic [IDX_W-1:0]    hdr_n;
  logic                xfer;
`ifdef ICACHE_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q;
`endif

  // Handshake: a word moves when in_valid and in_ready are both high at a
  // rising edge. in_ready is registered from the state being entered, so it
  // never depends combinationally on in_valid; in_data is ignored otherwise.
  assign xfer      = in_valid && in_ready_q;
  assign hdr_n     = IDX_W'(in_data);
  assign count_inc = count_q + IDX_W'(1);

  // Next-state selection; start only has effect from IDLE, RUN and ERROR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (xfer) begin
          if (hdr_n > IDX_W'(DEPTH)) state_d = S_ERROR;
          else if (hdr_n == '0)      state_d = S_POST;
          else                       state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer && (count_inc == n_q)) state_d = S_POST;
      end
`ifdef ICACHE_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) state_d = (sum_q == in_data) ? S_DRAIN : S_ERROR;
      end
`endif
      S_DRAIN: state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus all registered outputs and the write datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
      n_q        <= '0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == S_HEADER) || (state_d == S_LOAD)
`ifdef ICACHE_LOADER_CHECKSUM_EN
                    || (state_d == S_CHECK)
`endif
                    ;
      busy_q     <= (state_d == S_HEADER) || (state_d == S_LOAD) || (state_d == S_DRAIN)
`ifdef ICACHE_LOADER_CHECKSUM_EN
                    || (state_d == S_CHECK)
`endif
                    ;
      // cpu_run rises one cycle after RUN is entered, so DRAIN plus that
      // first RUN cycle give the store a settled read path; start drops it
      // on the same edge that leaves RUN.
      cpu_run_q  <= (state_q == S_RUN) && (state_d == S_RUN);
      error_q    <= (state_d == S_ERROR);
      we_q       <= 1'b0;
      if ((state_d == S_HEADER) && (state_q != S_HEADER)) begin
        count_q <= '0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
        sum_q   <= '0;
`endif
      end
      if ((state_q == S_HEADER) && xfer) n_q <= hdr_n;
      if ((state_q == S_LOAD) && xfer) begin
        idx_q   <= count_q;
        wdata_q <= in_data;
        we_q    <= 1'b1;
        count_q <= count_inc;
`ifdef ICACHE_LOADER_CHECKSUM_EN
        sum_q   <= sum_q + in_data;
`endif
      end
    end
  end

  assign in_ready        = in_ready_q;
  assign ic_write_enable = we_q;
  assign ic_write_index  = idx_q;
  assign ic_write_data   = wdata_q;
  assign cpu_run         = cpu_run_q;
  assign busy            = busy_q;
  assign error           = error_q;
  assign load_count      = count_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_icache_loader.sv
// tb_icache_loader: randomized scoreboard bench for icache_loader.
// Honours ICACHE_LOADER_CHECKSUM_EN the same way the design does.
module tb_icache_loader;

  localparam int DEPTH  = 128;
  localparam int IDX_W  = 32;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ic_write_enable;
  logic [IDX_W-1:0]  ic_write_index;
  logic [DATA_W-1:0] ic_write_data;
  logic              cpu_run;
  logic              busy;
  logic              error;
  logic [IDX_W-1:0]  load_count;
  logic [2:0]        dbg_state;

  int tests = 0;
  int fails = 0;

  // expected store writes: {index, data}
  logic [IDX_W+DATA_W-1:0] exp_q[$];
  logic [IDX_W+DATA_W-1:0] mon_e;

  icache_loader #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ic_write_enable(ic_write_enable), .ic_write_index(ic_write_index),
    .ic_write_data(ic_write_data), .cpu_run(cpu_run), .busy(busy),
    .error(error), .load_count(load_count), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every store write strobe must match the next expected write
  always @(negedge clk) begin
    if (!rst && ic_write_enable) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: idx %0d data %h, none expected", ic_write_index, ic_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ic_write_index, ic_write_data} !== mon_e) begin
          fails++;
          $display("FAIL write: got idx %0d data %h expected idx %0d data %h",
                   ic_write_index, ic_write_data, mon_e[IDX_W+DATA_W-1:DATA_W], mon_e[DATA_W-1:0]);
        end
      end
    end
  end

  // entered at #1 after a posedge or at a negedge; leaves at #1 after a posedge
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_cpu_run", cpu_run, 0);
    check("start_error", error, 0);
    check("start_in_ready", in_ready, 1);
    check("start_busy", busy, 1);
    check("start_count", load_count, 0);
    check("start_state", dbg_state, 3'd1);
    @(posedge clk); #1;
  endtask

  // driver: sends the stream honouring in_ready; gap 0=every cycle,
  // 1=one on two off, 2=random. Checks load_count every cycle.
  task automatic send_words(input logic [DATA_W-1:0] stream[$], input int n,
                            input int gap, input bit start_mid);
    int sent = 0;
    int phase = 0;
    int guard = 0;
    int exp_cnt;
    logic v;
    logic xf;
    while (sent < stream.size()) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (phase % 3 == 0);
        default: v = ($urandom_range(0, 1) == 0);
      endcase
      phase++;
      in_valid = v;
      in_data  = v ? stream[sent] : DATA_W'($urandom);
      start    = start_mid && (sent == 2);
      @(negedge clk);
      exp_cnt = (sent == 0) ? 0 : ((sent - 1 > n) ? n : sent - 1);
      check("load_count", load_count, exp_cnt);
      xf = in_valid && in_ready;
      @(posedge clk); #1;
      if (xf) sent++;
      guard++;
      if (guard > 4000) begin
        check("stream_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // one full load from start through the release (or error) checks
  task automatic run_load(input int n, input logic [DATA_W-1:0] prog[$], input int gap,
                          input bit start_mid, input bit bad_sum);
    logic [DATA_W-1:0] stream[$];
    logic [DATA_W-1:0] sum;
    bit exp_err;
    int exp_final;
    stream.push_back(DATA_W'(n));
    sum = '0;
    exp_err = (n > DEPTH) || bad_sum;
    exp_final = (n > DEPTH) ? 0 : n;
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        stream.push_back(prog[i]);
        exp_q.push_back({IDX_W'(i), prog[i]});
        sum = sum + prog[i];
      end
`ifdef ICACHE_LOADER_CHECKSUM_EN
      stream.push_back(bad_sum ? sum + 16'h0001 : sum);
`endif
    end
    pulse_start();
    send_words(stream, n, gap, start_mid);
    @(negedge clk);
    @(negedge clk);
    check("drain_cpu_run", cpu_run, 0);
    check("drain_write", ic_write_enable, 0);
    @(negedge clk);
    check("final_cpu_run", cpu_run, !exp_err);
    check("final_error", error, exp_err);
    check("final_busy", busy, 0);
    check("final_in_ready", in_ready, 0);
    check("final_count", load_count, exp_final);
    check("final_writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [DATA_W-1:0] p[$];
    logic [DATA_W-1:0] s[$];
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_we", ic_write_enable, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_idx", ic_write_index, 0);
    check("rst_data", ic_write_data, 0);
    check("rst_count", load_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic three-word program, back-to-back then gapped
    p = '{16'hA001, 16'hA002, 16'hA003};
    run_load(3, p, 0, 0, 0);
    run_load(3, p, 1, 0, 0);
    // oversize header, then empty program (start from ERROR clears error)
    run_load(129, p, 0, 0, 0);
    run_load(0, p, 0, 0, 0);

    // async reset after the second of four words
    p = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp_q.push_back({IDX_W'(0), p[0]});
    exp_q.push_back({IDX_W'(1), p[1]});
    pulse_start();
    s = '{16'd4, p[0], p[1]};
    send_words(s, 4, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_state", dbg_state, 0);
    check("arst_we", ic_write_enable, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_count", load_count, 0);
    check("arst_idx", ic_write_index, 0);
    check("arst_writes_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // start pulses during LOAD must be ignored
    run_load(4, p, 0, 1, 0);
    run_load(4, p, 2, 1, 0);

    // full-depth program
    p.delete();
    for (int i = 0; i < DEPTH; i++) p.push_back(DATA_W'($urandom));
    run_load(DEPTH, p, 2, 0, 0);

    // randomized programs, including occasional oversize headers
    for (int t = 0; t < 8; t++) begin
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(DEPTH + 1, 2000) : $urandom_range(0, 20);
      p.delete();
      for (int i = 0; i < 20; i++) p.push_back(DATA_W'($urandom));
      run_load(n, p, $urandom_range(0, 2), 0, 0);
    end

`ifdef ICACHE_LOADER_CHECKSUM_EN
    p = '{16'h1234, 16'h0001};
    run_load(2, p, 0, 0, 0);
    run_load(2, p, 1, 0, 1);
    run_load(0, p, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // overall time bound
  initial begin
    #3000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
